// File: rtl/sram_port_arbiter_pkg.sv
// Shared widths, starvation limit and state encoding for the SRAM port arbiter.
package sram_port_arbiter_pkg;

  localparam int ARB_ADDR_W       = 32;
  localparam int ARB_DATA_W       = 32;
  localparam int ARB_RDATA_W      = 64;
  localparam int ARB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_D = 2'b01,
    ARB_GNT_I = 2'b10
  } arb_state_t;

endpackage

// File: rtl/sram_port_arbiter_starve_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_starve_hit
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_W'(STARVE_LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starve_hit = (r_cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the single SRAM controller port: data side has
// priority, fetch is guaranteed a grant after STARVE_LIMIT back-to-back data grants.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int RDATA_W      = ARB_RDATA_W,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_ready,
  output logic [RDATA_W-1:0] d_rdata,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ready,
  output logic [RDATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0]  sram_address,
  output logic [DATA_W-1:0]  sram_write_data,
  output logic               sram_write_en,
  output logic               sram_read_en,
  input  logic [RDATA_W-1:0] sram_read_data,
  input  logic               sram_ready
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_starve_hit;
  logic              w_inc;
  logic              w_clr;
  logic              w_busy;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk          (clk),
    .rst          (rst),
    .i_inc        (w_inc),
    .i_clr        (w_clr),
    .o_starve_hit (w_starve_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Arbitration only happens in IDLE; a grant is held until the controller completes.
  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_clr  = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (d_req && i_req && w_starve_hit) begin
          w_next = ARB_GNT_I;
        end else if (d_req) begin
          w_next = ARB_GNT_D;
        end else if (i_req) begin
          w_next = ARB_GNT_I;
        end
        w_inc = (w_next == ARB_GNT_D) && i_req;
        w_clr = (w_next == ARB_GNT_I) || !i_req;
      end
      ARB_GNT_D, ARB_GNT_I: begin
        if (sram_ready) begin
          w_next = ARB_IDLE;
        end
      end
      default: begin
        w_next = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ARB_IDLE && w_next == ARB_GNT_D) begin
      r_we    <= d_we;
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
    end else if (r_state == ARB_IDLE && w_next == ARB_GNT_I) begin
      r_we    <= 1'b0;
      r_addr  <= i_addr;
      r_wdata <= '0;
    end
  end

  assign w_busy          = (r_state != ARB_IDLE);
  assign sram_read_en    = w_busy & ~r_we;
  assign sram_write_en   = w_busy & r_we;
  assign sram_address    = r_addr;
  assign sram_write_data = r_wdata;

  // Completion and read data are steered only to the requester that owns the grant.
  assign d_ready = (r_state == ARB_GNT_D) & sram_ready;
  assign i_ready = (r_state == ARB_GNT_I) & sram_ready;
  assign d_rdata = d_ready ? sram_read_data : '0;
  assign i_rdata = i_ready ? sram_read_data : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a transaction-level arbitration model
// predicts grants, a behavioural SRAM responder supplies completions and data.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int LIMIT   = ARB_STARVE_LIMIT;
  localparam int TIMEOUT = 200;

  typedef struct {
    int                    who;
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } grant_t;

  typedef struct {
    logic [ARB_RDATA_W-1:0] data;
    int                     cycles;
  } resp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   d_req = 1'b1;
  logic                   d_we = 1'b0;
  logic [ARB_ADDR_W-1:0]  d_addr = 32'h0000_0100;
  logic [ARB_DATA_W-1:0]  d_wdata = 32'h0;
  logic                   d_ready;
  logic [ARB_RDATA_W-1:0] d_rdata;
  logic                   i_req = 1'b1;
  logic [ARB_ADDR_W-1:0]  i_addr = 32'h0000_2000;
  logic                   i_ready;
  logic [ARB_RDATA_W-1:0] i_rdata;
  logic [ARB_ADDR_W-1:0]  sram_address;
  logic [ARB_DATA_W-1:0]  sram_write_data;
  logic                   sram_write_en;
  logic                   sram_read_en;
  logic [ARB_RDATA_W-1:0] sram_read_data = 64'h0;
  logic                   sram_ready = 1'b0;

  int     checks = 0;
  int     errors = 0;
  grant_t grantQ[$];
  resp_t  respQ[$];
  int     readyLog[$];
  grant_t cur;
  resp_t  resp;
  int     mOwner = 0;
  int     mStreak = 0;
  int     winner;
  int     enCount = 0;
  int     lastEnCount = 0;
  logic   prevEn = 1'b0;
  logic   en;
  int     sramDelay = -1;
  logic   useFixed = 1'b0;
  logic   spuriousOn = 1'b0;
  logic   forceSpurious = 1'b0;
  int     expOrder[6] = '{1, 1, 1, 1, 2, 1};

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_ready         (d_ready),
    .d_rdata         (d_rdata),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .i_ready         (i_ready),
    .i_rdata         (i_rdata),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_write_en   (sram_write_en),
    .sram_read_en    (sram_read_en),
    .sram_read_data  (sram_read_data),
    .sram_ready      (sram_ready)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Waits for this requester's ready pulse; optionally drops and scrambles the data request once the SRAM is busy.
  task automatic waitReady(input logic isD, input logic dropEarly, input string name);
    int   n = 0;
    logic dropPending = dropEarly;
    forever begin
      @(negedge clk);
      if (isD ? d_ready : i_ready) break;
      n++;
      if (n > TIMEOUT) begin
        reportFail(name, $sformatf("no ready pulse within %0d cycles, required one", TIMEOUT));
        break;
      end
      if (dropPending && (sram_read_en || sram_write_en)) begin
        dropPending = 1'b0;
        @(posedge clk);
        #1;
        d_req   = 1'b0;
        d_we    = ~d_we;
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end
  endtask

  task automatic dTxn(input logic we, input logic [ARB_ADDR_W-1:0] addr,
                      input logic [ARB_DATA_W-1:0] wdata, input logic dropEarly);
    @(posedge clk);
    #1;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    waitReady(1'b1, dropEarly, "d_timeout");
  endtask

  task automatic iTxn(input logic [ARB_ADDR_W-1:0] addr);
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = addr;
    waitReady(1'b0, 1'b0, "i_timeout");
  endtask

  task automatic applyStimulus();
    fork
      begin
        repeat (40) begin
          dTxn(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
          if ($urandom_range(0, 2) != 0) begin
            @(posedge clk);
            #1;
            d_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
          end
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
      end
      begin
        repeat (25) begin
          iTxn($urandom);
          @(posedge clk);
          #1;
          i_req = 1'b0;
          repeat ($urandom_range(0, 4)) @(posedge clk);
        end
      end
    join
  endtask

  // SRAM controller stand-in: completes each access after a chosen delay and may pulse ready while idle.
  initial begin : sramResponder
    int waitLeft;
    int total;
    waitLeft = -1;
    total = 0;
    forever begin
      @(posedge clk);
      #1;
      sram_ready     = 1'b0;
      sram_read_data = {$urandom, $urandom};
      if (!rst) begin
        waitLeft = -1;
      end else if (sram_read_en || sram_write_en) begin
        if (waitLeft < 0) begin
          waitLeft = (sramDelay >= 0) ? sramDelay : int'($urandom_range(0, 3));
          total    = waitLeft + 1;
        end
        if (waitLeft == 0) begin
          sram_ready = 1'b1;
          if (useFixed) sram_read_data = 64'h1111_2222_3333_4444;
          respQ.push_back('{sram_read_data, total});
          waitLeft = -1;
        end else begin
          waitLeft--;
        end
      end else begin
        waitLeft = -1;
        if (forceSpurious || (spuriousOn && $urandom_range(0, 5) == 0)) sram_ready = 1'b1;
      end
    end
  end

  // Monitor compares DUT activity with queued expectations, then the model decides the next grant.
  initial begin : scoreboard
    forever begin
      @(negedge clk);
      en = sram_read_en | sram_write_en;
      if (!rst) begin
        checkOutput("reset_enables", 64'({sram_write_en, sram_read_en}), 64'h0);
        checkOutput("reset_readies", 64'({d_ready, i_ready}), 64'h0);
        checkOutput("reset_rdata", d_rdata | i_rdata, 64'h0);
        checkOutput("reset_address", 64'(sram_address), 64'h0);
        checkOutput("reset_wdata", 64'(sram_write_data), 64'h0);
        mOwner  = 0;
        mStreak = 0;
        grantQ.delete();
        respQ.delete();
      end else begin
        if (en && !prevEn) begin
          if (grantQ.size() == 0) begin
            reportFail("unexpected_grant", "SRAM enable rose, required no grant");
          end else begin
            cur = grantQ.pop_front();
          end
          enCount = 0;
        end else if (grantQ.size() != 0) begin
          reportFail("missing_grant", "SRAM enable low, required a new grant");
          grantQ.delete(0);
        end
        if (en) begin
          enCount++;
          checkOutput("sram_address", 64'(sram_address), 64'(cur.addr));
          checkOutput("sram_write_data", 64'(sram_write_data), 64'(cur.wdata));
          checkOutput("sram_enables", 64'({sram_write_en, sram_read_en}), 64'(cur.we ? 2'b10 : 2'b01));
        end
        if (d_ready || i_ready) begin
          if (respQ.size() == 0) begin
            reportFail("spurious_ready", $sformatf("d_ready=%0b i_ready=%0b, required none", d_ready, i_ready));
          end else begin
            resp = respQ.pop_front();
            checkOutput("ready_owner", 64'({d_ready, i_ready}), 64'(cur.who == 1 ? 2'b10 : 2'b01));
            checkOutput("ready_rdata", d_ready ? d_rdata : i_rdata, resp.data);
            checkOutput("enable_cycles", 64'(enCount), 64'(resp.cycles));
            readyLog.push_back(d_ready ? 1 : 2);
            lastEnCount = enCount;
          end
        end else if (respQ.size() != 0) begin
          reportFail("missing_ready", "no ready pulse, required one");
          respQ.delete(0);
        end
        if (!d_ready) checkOutput("d_rdata_zero", d_rdata, 64'h0);
        if (!i_ready) checkOutput("i_rdata_zero", i_rdata, 64'h0);

        if (mOwner == 0) begin
          winner = 0;
          if (d_req && i_req && mStreak >= LIMIT) winner = 2;
          else if (d_req) winner = 1;
          else if (i_req) winner = 2;
          if (winner == 1 && i_req) mStreak = (mStreak < LIMIT) ? mStreak + 1 : LIMIT;
          else if (winner == 2 || !i_req) mStreak = 0;
          if (winner == 1) grantQ.push_back('{1, d_we, d_addr, d_wdata});
          if (winner == 2) grantQ.push_back('{2, 1'b0, i_addr, 32'h0});
          mOwner = winner;
        end else if (sram_ready) begin
          mOwner = 0;
        end
      end
      prevEn = en;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    // Both requesters waiting through reset, then sustained contention.
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    readyLog.delete();
    fork
      begin
        @(negedge clk);
        checkOutput("t1_idle_after_release", 64'({sram_write_en, sram_read_en}), 64'h0);
        @(negedge clk);
        checkOutput("t1_first_grant_d", 64'({sram_write_en, sram_read_en}), 64'h1);
        checkOutput("t1_first_addr", 64'(sram_address), 64'h100);
      end
      repeat (5) dTxn(1'b0, $urandom, $urandom, 1'b0);
      begin
        iTxn(32'h0000_2000);
        @(posedge clk);
        #1;
        i_req = 1'b0;
      end
    join
    @(posedge clk);
    #1;
    d_req = 1'b0;
    checkOutput("t3_grant_count", 64'(readyLog.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("t3_order_%0d", k), 64'(k < readyLog.size() ? readyLog[k] : 0), 64'(expOrder[k]));
    end

    // Single read with fixed SRAM latency and data.
    repeat (2) @(posedge clk);
    sramDelay = 2;
    useFixed  = 1'b1;
    dTxn(1'b0, 32'h0000_0400, 32'h0, 1'b0);
    #1;
    checkOutput("t2_d_rdata", d_rdata, 64'h1111_2222_3333_4444);
    checkOutput("t2_i_ready", 64'(i_ready), 64'h0);
    checkOutput("t2_read_en_cycles", 64'(lastEnCount), 64'd3);
    @(posedge clk);
    #1;
    d_req    = 1'b0;
    useFixed = 1'b0;

    // Write whose request is withdrawn and scrambled right after the grant.
    repeat (2) @(posedge clk);
    dTxn(1'b1, 32'h0000_0800, 32'hDEAD_BEEF, 1'b1);
    #1;
    checkOutput("t4_address", 64'(sram_address), 64'h800);
    checkOutput("t4_wdata", 64'(sram_write_data), 64'hDEAD_BEEF);
    checkOutput("t4_write_en", 64'({sram_write_en, sram_read_en}), 64'h2);
    checkOutput("t4_write_en_cycles", 64'(lastEnCount), 64'd3);

    // Controller ready pulses while idle must be ignored.
    repeat (2) @(posedge clk);
    #1;
    forceSpurious = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    forceSpurious = 1'b0;
    @(negedge clk);
    checkOutput("t6_stays_idle", 64'({sram_write_en, sram_read_en}), 64'h0);

    // Reset in the middle of a fetch, then a fresh fetch grant.
    sramDelay = 10;
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 32'h0000_0C00;
    for (int n = 0; n < TIMEOUT && !sram_read_en; n++) @(negedge clk);
    checkOutput("t5_fetch_granted", 64'(sram_read_en), 64'h1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_read_en_drops", 64'(sram_read_en), 64'h0);
    sramDelay = 1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    waitReady(1'b0, 1'b0, "t5_fresh_fetch");
    #1;
    checkOutput("t5_fresh_fetch_addr", 64'(sram_address), 64'hC00);
    @(posedge clk);
    #1;
    i_req = 1'b0;

    // Randomised contention with spurious controller pulses.
    sramDelay  = -1;
    spuriousOn = 1'b1;
    applyStimulus();
    spuriousOn = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("final_grants_drained", 64'(grantQ.size()), 64'h0);
    checkOutput("final_responses_drained", 64'(respQ.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
